// File: rtl/sma_pkg.sv
// Shared definitions for the SMA bounds engine: field layout, policy and bounds math.
package sma_pkg;

  // Default field layout of a tagged pointer (MSB first: b_size, l_size, ..., address).
  localparam int DEF_WORD_WIDTH   = 64;
  localparam int DEF_BSIZE_WIDTH  = 6;
  localparam int DEF_LENGTH_WIDTH = 4;
  localparam int DEF_PTR_WIDTH    = 48;
  localparam int DEF_TAG_WIDTH    = 4;
  localparam int DEF_CNT_WIDTH    = 16;

  // Widest word the bounds function handles; narrower words are masked down.
  localparam int MAX_WORD = 64;
  localparam logic [MAX_WORD-1:0] ONE_W = MAX_WORD'(1);

  typedef enum logic {
    CLAMP = 1'b0,
    TRAP  = 1'b1
  } policy_e;

  typedef struct packed {
    logic [MAX_WORD-1:0] lower;
    logic [MAX_WORD-1:0] last;
  } bounds_t;

  // Lowest legal address and last legal access-aligned address of an object.
  function automatic bounds_t calc_bounds(
    input logic [MAX_WORD-1:0] ptr,
    input logic [7:0]          b_size,
    input logic [MAX_WORD-1:0] l_size,
    input logic [2:0]          access_type,
    input int unsigned         word_w
  );
    logic [MAX_WORD-1:0] mask;
    logic [MAX_WORD-1:0] upper;
    int unsigned         lsh;
    bounds_t             b;
    mask = {MAX_WORD{1'b1}} >> (32'(MAX_WORD) - word_w);
    lsh  = 32'(b_size) + 32'd4;
    // Alignment shift past the word leaves no address bits in the base.
    if (lsh >= word_w) b.lower = '0;
    else               b.lower = ptr & (mask << lsh);
    upper  = (b.lower | (l_size << b_size)) & mask;
    b.last = (upper - ONE_W) & mask & (mask << access_type);
    return b;
  endfunction

endpackage

// File: rtl/sma_engine_pipe_if.sv
// Request/result handshake and fault status bundle of the SMA engine.
interface sma_engine_pipe_if #(
  parameter int WORD_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            access_type;
  logic [WORD_WIDTH-1:0] tagged_pointer;
  logic [WORD_WIDTH-1:0] increment;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  trap_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] sma_address;
  logic                  overflow;
  logic                  underflow;
  logic                  trap;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  fault_clear;
  logic [1:0]            fault_sticky;
  logic [CNT_WIDTH-1:0]  fault_count;

  modport master (
    output in_valid, access_type, tagged_pointer, increment, in_tag, trap_en,
           out_ready, fault_clear,
    input  in_ready, out_valid, sma_address, overflow, underflow, trap, out_tag,
           fault_sticky, fault_count
  );

  modport slave (
    input  in_valid, access_type, tagged_pointer, increment, in_tag, trap_en,
           out_ready, fault_clear,
    output in_ready, out_valid, sma_address, overflow, underflow, trap, out_tag,
           fault_sticky, fault_count
  );
endinterface

// File: rtl/sma_bounds_decode.sv
// Combinational decode of a tagged pointer into address, object bounds and empty flag.
module sma_bounds_decode
  import sma_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int BSIZE_WIDTH  = DEF_BSIZE_WIDTH,
  parameter int LENGTH_WIDTH = DEF_LENGTH_WIDTH,
  parameter int PTR_WIDTH    = DEF_PTR_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] i_tagged_pointer,
  input  logic [2:0]            i_access_type,
  output logic [WORD_WIDTH-1:0] o_ptr,
  output logic [WORD_WIDTH-1:0] o_lower,
  output logic [WORD_WIDTH-1:0] o_last,
  output logic                  o_empty
);
  localparam logic [WORD_WIDTH-1:0] PTR_MASK = WORD_WIDTH'({PTR_WIDTH{1'b1}});

  logic [BSIZE_WIDTH-1:0]  w_b_size;
  logic [LENGTH_WIDTH-1:0] w_l_size;
  bounds_t                 w_bounds;

  assign w_b_size = i_tagged_pointer[WORD_WIDTH-1 -: BSIZE_WIDTH];
  assign w_l_size = i_tagged_pointer[WORD_WIDTH-BSIZE_WIDTH-1 -: LENGTH_WIDTH];
  assign o_ptr    = i_tagged_pointer & PTR_MASK;
  assign o_empty  = (w_l_size == '0);

  // Bounds math shared with any other consumer through the package function.
  always_comb begin
    w_bounds = calc_bounds(MAX_WORD'(o_ptr), 8'(w_b_size), MAX_WORD'(w_l_size),
                           i_access_type, WORD_WIDTH);
  end

  assign o_lower = w_bounds.lower[WORD_WIDTH-1:0];
  assign o_last  = w_bounds.last[WORD_WIDTH-1:0];
endmodule

// File: rtl/sma_engine_pipe.sv
// Two-stage pipelined SMA bounds engine: decode/sum, then compare/select, with fault accounting.
module sma_engine_pipe
  import sma_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int BSIZE_WIDTH  = DEF_BSIZE_WIDTH,
  parameter int LENGTH_WIDTH = DEF_LENGTH_WIDTH,
  parameter int PTR_WIDTH    = DEF_PTR_WIDTH,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  sma_engine_pipe_if.slave bus
);
  localparam int W = WORD_WIDTH;

  logic [W-1:0] w_ptr, w_lower, w_last;
  logic         w_empty;
  logic [W:0]   w_sum;

  sma_bounds_decode #(
    .WORD_WIDTH   (WORD_WIDTH),
    .BSIZE_WIDTH  (BSIZE_WIDTH),
    .LENGTH_WIDTH (LENGTH_WIDTH),
    .PTR_WIDTH    (PTR_WIDTH)
  ) u_decode (
    .i_tagged_pointer (bus.tagged_pointer),
    .i_access_type    (bus.access_type),
    .o_ptr            (w_ptr),
    .o_lower          (w_lower),
    .o_last           (w_last),
    .o_empty          (w_empty)
  );

  // One extra bit keeps the sign of ptr + increment.
  assign w_sum = {1'b0, w_ptr} + {bus.increment[W-1], bus.increment};

  logic                 r_s1_valid, r_s1_empty;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  policy_e              r_s1_policy;
  logic [W-1:0]         r_s1_lower, r_s1_last;
  logic [W:0]           r_s1_sum;

  logic                 r_s2_valid, r_s2_ovf, r_s2_unf, r_s2_trap;
  logic [TAG_WIDTH-1:0] r_s2_tag;
  logic [W-1:0]         r_s2_addr;

  logic [1:0]           r_sticky;
  logic [CNT_WIDTH-1:0] r_count;

  logic w_s2_adv, w_in_ready, w_out_fire;
  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_out_fire = r_s2_valid && bus.out_ready;

  // Stage 1: capture decoded bounds and the signed sum of an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_empty  <= 1'b0;
      r_s1_tag    <= '0;
      r_s1_policy <= CLAMP;
      r_s1_lower  <= '0;
      r_s1_last   <= '0;
      r_s1_sum    <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_empty  <= w_empty;
        r_s1_tag    <= bus.in_tag;
        r_s1_policy <= policy_e'(bus.trap_en);
        r_s1_lower  <= w_lower;
        r_s1_last   <= w_last;
        r_s1_sum    <= w_sum;
      end
    end
  end

  logic         w_neg, w_range, w_ovf, w_unf, w_fault, w_trap;
  logic [W-1:0] w_sum_lo, w_addr;

  assign w_neg    = r_s1_sum[W];
  assign w_sum_lo = r_s1_sum[W-1:0];
  assign w_range  = |w_sum_lo[W-1:PTR_WIDTH];
  // Overflow takes priority, so underflow is masked whenever overflow holds.
  assign w_ovf    = r_s1_empty || (!w_neg && (w_range || (w_sum_lo > r_s1_last)));
  assign w_unf    = !w_ovf && (w_neg || (w_sum_lo < r_s1_lower));
  assign w_fault  = w_ovf || w_unf;
  assign w_trap   = w_fault && (r_s1_policy == TRAP);

  // Result select: trap zeroes, clamp pins to the violated bound (empty objects pin low).
  always_comb begin
    w_addr = w_sum_lo;
    if (w_trap)                    w_addr = '0;
    else if (w_unf || r_s1_empty)  w_addr = r_s1_lower;
    else if (w_ovf)                w_addr = r_s1_last;
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_unf   <= 1'b0;
      r_s2_trap  <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_addr  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_ovf  <= w_ovf;
        r_s2_unf  <= w_unf;
        r_s2_trap <= w_trap;
        r_s2_tag  <= r_s1_tag;
        r_s2_addr <= w_addr;
      end
    end
  end

  // Fault accounting on accepted results; an explicit clear overrides a same-cycle fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else if (bus.fault_clear) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else if (w_out_fire && (r_s2_ovf || r_s2_unf)) begin
      r_sticky <= r_sticky | {r_s2_ovf, r_s2_unf};
      if (r_count != {CNT_WIDTH{1'b1}}) r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_s2_valid;
  assign bus.sma_address  = r_s2_addr;
  assign bus.overflow     = r_s2_ovf;
  assign bus.underflow    = r_s2_unf;
  assign bus.trap         = r_s2_trap;
  assign bus.out_tag      = r_s2_tag;
  assign bus.fault_sticky = r_sticky;
  assign bus.fault_count  = r_count;
endmodule

// File: tb/tb_sma_engine_pipe.sv
// Self-checking bench: directed vector table, random stream with backpressure, fault and reset sequences.
module tb_sma_engine_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sma_engine_pipe_if bus_if ();

  sma_engine_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] addr;
    bit          ovf;
    bit          unf;
    bit          trp;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    logic [63:0] tp;
    logic [63:0] inc;
    logic [2:0]  at;
    bit          te;
    logic [63:0] exp_addr;
    bit          exp_ovf;
    bit          exp_unf;
    bit          exp_trp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bounds from arithmetic on an unbounded-width signed number line.
  function automatic res_t ref_model(input logic [63:0] tp, input logic [63:0] inc,
                                     input logic [2:0] at, input bit te);
    logic signed [127:0] ptr, lower, upper, last, sum, gran, two64, lim, lv, incx;
    int   b;
    bit   ovf, unf, empty;
    res_t r;
    two64 = '0; two64[64] = 1'b1;
    lim   = '0; lim[48]   = 1'b1;
    ptr   = '0; ptr[47:0] = tp[47:0];
    lv    = '0; lv[3:0]   = tp[57:54];
    b     = int'(tp[63:58]);
    empty = (tp[57:54] == 4'd0);
    if (b + 4 >= 64) lower = '0;
    else begin
      gran  = 128'sd1 <<< (b + 4);
      lower = ptr - (ptr % gran);
    end
    upper = (lower + lv * (128'sd1 <<< b)) % two64;
    if (upper == '0) last = two64 - 128'sd1;
    else             last = upper - 128'sd1;
    gran = 128'sd1 <<< int'(at);
    last = last - (last % gran);
    incx = {{64{inc[63]}}, inc};
    sum  = ptr + incx;
    ovf  = empty || (sum >= lim) || (sum > last);
    unf  = !ovf && ((sum < 128'sd0) || (sum < lower));
    r.ovf = ovf;
    r.unf = unf;
    r.trp = te && (ovf || unf);
    r.tag = '0;
    if (r.trp)              r.addr = '0;
    else if (unf || empty)  r.addr = lower[63:0];
    else if (ovf)           r.addr = last[63:0];
    else                    r.addr = sum[63:0];
    return r;
  endfunction

  task automatic drive(input logic [63:0] tp, input logic [63:0] inc, input logic [2:0] at,
                       input bit te, input logic [3:0] tag);
    bus_if.tagged_pointer = tp;
    bus_if.increment      = inc;
    bus_if.access_type    = at;
    bus_if.trap_en        = te;
    bus_if.in_tag         = tag;
  endtask

  // Presents one request with out_ready high; returns at the negedge where its result is visible.
  task automatic send_one(input logic [63:0] tp, input logic [63:0] inc, input logic [2:0] at,
                          input bit te, input logic [3:0] tag);
    drive(tp, inc, at, te, tag);
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("accept_ready", 64'(bus_if.in_ready), 64'd1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", 64'(bus_if.out_valid), 64'd0);
    @(negedge clk);
    check("latency_two", 64'(bus_if.out_valid), 64'd1);
  endtask

  task automatic pulse_clear();
    bus_if.fault_clear = 1'b1;
    @(posedge clk); #1;
    bus_if.fault_clear = 1'b0;
  endtask

  localparam logic [63:0] P = 64'h0200_0000_0000_1000;
  localparam int NVEC  = 12;
  localparam int NRAND = 60;

  vec_t vecs[NVEC];
  res_t exp_q[$];

  logic [63:0] r_tp, r_inc;
  logic [2:0]  r_at;
  bit          r_te;

  task automatic gen_req(input logic [3:0] tag);
    int b, s;
    logic [47:0] p48;
    b   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 63));
    p48 = 48'({$urandom, $urandom});
    r_tp = {6'(b), 4'($urandom_range(0, 15)), 6'($urandom), p48};
    case ($urandom_range(0, 3))
      0, 1: begin s = int'($urandom_range(0, 255)) - 128; r_inc = 64'(longint'(s)); end
      2: begin
        s = int'($urandom_range(0, 65535)) - 32768;
        r_inc = 64'(longint'(s)) << ($urandom_range(0, 12));
      end
      default: r_inc = {$urandom, $urandom};
    endcase
    r_at = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
    r_te = ($urandom_range(0, 2) == 0);
    drive(r_tp, r_inc, r_at, r_te, tag);
  endtask

  initial begin
    vecs[0]  = '{P, 64'd3, 3'd0, 1'b0, 64'h1003, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{P, 64'h10, 3'd2, 1'b0, 64'h1004, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{P, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 64'h1000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{P, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{64'h0000_0000_0000_1000, 64'd0, 3'd0, 1'b0, 64'h1000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{P, 64'h10, 3'd2, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{P, 64'd7, 3'd0, 1'b0, 64'h1007, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{P, 64'd8, 3'd0, 1'b0, 64'h1007, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{P, 64'd0, 3'd0, 1'b1, 64'h1000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{64'h0200_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFE0, 3'd0, 1'b0, 64'h10, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{64'hFC40_FFFF_FFFF_FFFF, 64'd1, 3'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{64'h0000_0000_0000_1000, 64'd0, 3'd0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};

    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.fault_clear = 1'b0;
    drive('0, '0, 3'd0, 1'b0, 4'd0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    check("rst_addr", bus_if.sma_address, 64'd0);
    check("rst_flags", 64'({bus_if.overflow, bus_if.underflow, bus_if.trap}), 64'd0);
    check("rst_tag", 64'(bus_if.out_tag), 64'd0);
    check("rst_sticky", 64'(bus_if.fault_sticky), 64'd0);
    check("rst_count", 64'(bus_if.fault_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < NVEC; i++) begin
      send_one(vecs[i].tp, vecs[i].inc, vecs[i].at, vecs[i].te, 4'(i));
      check($sformatf("vec%0d_addr", i), bus_if.sma_address, vecs[i].exp_addr);
      check($sformatf("vec%0d_ovf", i), 64'(bus_if.overflow), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_unf", i), 64'(bus_if.underflow), 64'(vecs[i].exp_unf));
      check($sformatf("vec%0d_trap", i), 64'(bus_if.trap), 64'(vecs[i].exp_trp));
      check($sformatf("vec%0d_tag", i), 64'(bus_if.out_tag), 64'(i));
      @(posedge clk); #1;
    end

    // Random stream with random backpressure against the reference model
    begin
      int sent = 0, recv = 0, exp_cnt = 0;
      logic [1:0] exp_sticky = 2'b00;
      bit have_snap = 1'b0, in_fire;
      res_t snap, got, e;
      pulse_clear();
      gen_req(4'(sent));
      bus_if.in_valid = 1'b1;
      bus_if.out_ready = 1'b0;
      for (int cyc = 0; cyc < 4000 && recv < NRAND; cyc++) begin
        @(negedge clk);
        got = '{bus_if.sma_address, bus_if.overflow, bus_if.underflow, bus_if.trap, bus_if.out_tag};
        if (have_snap) begin
          have_snap = 1'b0;
          check("stall_valid", 64'(bus_if.out_valid), 64'd1);
          check("stall_addr", got.addr, snap.addr);
          check("stall_tag_flags", 64'({got.tag, got.ovf, got.unf, got.trp}),
                64'({snap.tag, snap.ovf, snap.unf, snap.trp}));
        end
        if (bus_if.out_valid) begin
          if (bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
              check("extra_result", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("rnd%0d_tag", recv), 64'(got.tag), 64'(e.tag));
              check($sformatf("rnd%0d_addr", recv), got.addr, e.addr);
              check($sformatf("rnd%0d_flags", recv), 64'({got.ovf, got.unf, got.trp}),
                    64'({e.ovf, e.unf, e.trp}));
              if (e.ovf || e.unf) begin
                exp_cnt++;
                exp_sticky = exp_sticky | {e.ovf, e.unf};
              end
            end
            recv++;
          end else begin
            snap = got;
            have_snap = 1'b1;
          end
        end
        in_fire = bus_if.in_valid && bus_if.in_ready;
        if (in_fire) begin
          e = ref_model(r_tp, r_inc, r_at, r_te);
          e.tag = 4'(sent);
          exp_q.push_back(e);
          sent++;
        end
        @(posedge clk); #1;
        bus_if.out_ready = ($urandom_range(0, 9) < 6);
        if (in_fire || !bus_if.in_valid) begin
          if (sent < NRAND) begin
            gen_req(4'(sent));
            bus_if.in_valid = ($urandom_range(0, 3) != 0);
          end else begin
            bus_if.in_valid = 1'b0;
          end
        end
      end
      check("rnd_all_received", 64'(recv), 64'(NRAND));
      check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      check("rnd_fault_count", 64'(bus_if.fault_count), 64'(exp_cnt));
      check("rnd_fault_sticky", 64'(bus_if.fault_sticky), 64'(exp_sticky));
      @(posedge clk); #1;
    end

    // Fault accounting: three counted faults, then a clear colliding with a fourth
    pulse_clear();
    for (int i = 0; i < 3; i++) begin
      send_one(P, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 4'(i));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("fa_count3", 64'(bus_if.fault_count), 64'd3);
    check("fa_sticky_unf", 64'(bus_if.fault_sticky), 64'b01);
    @(posedge clk); #1;
    send_one(P, 64'h10, 3'd2, 1'b0, 4'd3);
    check("fa_4th_ovf", 64'(bus_if.overflow), 64'd1);
    bus_if.fault_clear = 1'b1;
    @(posedge clk); #1;
    bus_if.fault_clear = 1'b0;
    @(negedge clk);
    check("fa_count_cleared", 64'(bus_if.fault_count), 64'd0);
    check("fa_sticky_cleared", 64'(bus_if.fault_sticky), 64'd0);
    check("fa_result_taken", 64'(bus_if.out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a stalled stream
    send_one(P, 64'h10, 3'd2, 1'b0, 4'd9);
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(P, 64'(i), 3'd0, 1'b0, 4'(i));
      bus_if.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    check("mid_full_valid", 64'(bus_if.out_valid), 64'd1);
    check("mid_full_blocked", 64'(bus_if.in_ready), 64'd0);
    check("mid_count_before", 64'(bus_if.fault_count), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus_if.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus_if.in_ready), 64'd1);
    check("mid_rst_addr", bus_if.sma_address, 64'd0);
    check("mid_rst_count", 64'(bus_if.fault_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_stale", 64'(bus_if.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
